// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: operation
// encodings, FSM states and small decode helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Odd encodings are the unsigned variants of every operation class.
  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

  function automatic int lat_w(input int mult_lat, input int div_lat);
    int m;
    m = (mult_lat > div_lat) ? mult_lat : div_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Handshake/data bundle between the E stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic             clear;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, clear,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, clear,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_divider.sv
// Combinational signed/unsigned divider with divide-by-zero and MIN/-1
// special cases folded in; quotient truncates toward zero.
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_n;
  logic             neg_d;
  logic [WIDTH-1:0] mag_n;
  logic [WIDTH-1:0] mag_d;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_r;

  // Divide magnitudes, then restore signs: quotient negative when signs differ,
  // remainder follows the dividend.
  always_comb begin
    neg_n = is_signed & dividend[WIDTH-1];
    neg_d = is_signed & divisor[WIDTH-1];
    mag_n = neg_n ? (~dividend + 1'b1) : dividend;
    mag_d = neg_d ? (~divisor + 1'b1) : divisor;
    mag_q = '0;
    mag_r = '0;
    if (divisor != '0) begin
      mag_q = mag_n / mag_d;
      mag_r = mag_n % mag_d;
    end
    quo = (neg_n ^ neg_d) ? (~mag_q + 1'b1) : mag_q;
    rem = neg_n ? (~mag_r + 1'b1) : mag_r;
    if (divisor == '0) begin
      quo = '1;
      rem = dividend;
    end else if (is_signed && (dividend == MIN_VAL) && (divisor == '1)) begin
      quo = MIN_VAL;
      rem = '0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at start, held in a pending register, and committed when the counter expires.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  localparam int DW    = 2 * WIDTH;
  localparam int LAT_W = lat_w(MULT_LAT, DIV_LAT);

  localparam logic [LAT_W-1:0] MULT_CNT = LAT_W'(MULT_LAT);
  localparam logic [LAT_W-1:0] DIV_CNT  = LAT_W'(DIV_LAT);
  localparam logic [LAT_W-1:0] CNT_ONE  = LAT_W'(1);

  op_e              op_d;
  logic             sgn;
  logic [DW-1:0]    ext_a;
  logic [DW-1:0]    ext_b;
  logic [DW-1:0]    prod;
  logic [DW-1:0]    acc;
  logic [DW-1:0]    target;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             launch;

  state_e           state_q;
  logic [LAT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [DW-1:0]    res_q;

  assign op_d   = op_e'(bus.op);
  assign sgn    = is_signed_op(op_d);
  assign launch = (state_q == ST_IDLE) && bus.start && !bus.clear;

  muldiv_divider #(.WIDTH(WIDTH)) u_div (
    .dividend  (bus.a),
    .divisor   (bus.b),
    .is_signed (sgn),
    .quo       (quo),
    .rem       (rem)
  );

  // Operands are extended to 2*WIDTH so one unsigned multiply yields the
  // correct wrapped product for both signed and unsigned forms.
  always_comb begin
    ext_a  = sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    ext_b  = sgn ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    prod   = ext_a * ext_b;
    acc    = {hi_q, lo_q};
    target = prod;
    case (op_d)
      OP_MULT, OP_MULTU: target = prod;
      OP_MADD, OP_MADDU: target = acc + prod;
      OP_MSUB, OP_MSUBU: target = acc - prod;
      default:           target = {rem, quo};
    endcase
  end

  // Pending result: captured only when an operation is accepted.
  always_ff @(posedge clk) begin
    if (launch) res_q <= target;
  end

  // Control FSM, latency counter and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.clear) begin
            state_q <= ST_IDLE;
          end else if (bus.start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= is_div(op_d) ? DIV_CNT : MULT_CNT;
          end else begin
            if (bus.wr_hi) hi_q <= bus.a;
            if (bus.wr_lo) lo_q <= bus.a;
          end
        end
        ST_RUN: begin
          if (bus.clear) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_ONE) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            {hi_q, lo_q} <= res_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: a 32-bit default instance for directed/random tests and a
// 16-bit instance (MULT_LAT=1, DIV_LAT=16) for the parameter sweep.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) b32 ();
  muldiv_if #(.WIDTH(16)) b16 ();

  muldiv_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32.slave)
  );

  muldiv_unit #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] e_hi32, e_lo32;
  logic [15:0] e_hi16, e_lo16;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sext(input logic [31:0] x, input int w);
    logic signed [31:0] s32;
    logic signed [15:0] s16;
    s32 = x;
    s16 = x[15:0];
    return (w == 32) ? longint'(s32) : longint'(s16);
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic void ref_op(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo,
                                 output logic [31:0] rhi, output logic [31:0] rlo);
    logic [63:0] m, m2, pa, pb, prod, acc, r;
    longint sa, sb, q, rm;
    bit uns;
    m   = (64'd1 << w) - 64'd1;
    m2  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    uns = op[0];
    sa  = uns ? longint'({32'd0, a} & m) : sext(a, w);
    sb  = uns ? longint'({32'd0, b} & m) : sext(b, w);
    pa = sa; pb = sb;
    prod = pa * pb;
    acc  = ((({32'd0, hi}) & m) << w) | (({32'd0, lo}) & m);
    case (op)
      3'd0, 3'd1: r = prod;
      3'd4, 3'd5: r = acc + prod;
      3'd6, 3'd7: r = acc - prod;
      default: begin
        if (sb == 0) begin
          q = longint'(m); rm = sa;
        end else if (!uns && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
          q = longint'(1) << (w - 1); rm = 0;
        end else begin
          q = sa / sb; rm = sa % sb;
        end
        r = ((64'(rm) & m) << w) | (64'(q) & m);
      end
    endcase
    r   = r & m2;
    rhi = 32'((r >> w) & m);
    rlo = 32'(r & m);
  endfunction

  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit with_wr, input string tag);
    logic [31:0] rh, rl;
    int lat;
    lat = (op == 3'd2 || op == 3'd3) ? 10 : 5;
    ref_op(32, op, a, b, e_hi32, e_lo32, rh, rl);
    b32.op = op; b32.a = a; b32.b = b; b32.start = 1'b1;
    b32.wr_hi = with_wr; b32.wr_lo = with_wr;
    tick();
    b32.start = 1'b0; b32.wr_hi = 1'b0; b32.wr_lo = 1'b0;
    for (int i = 0; i < lat; i++) begin
      n_cmp++;
      if (b32.busy !== 1'b1 || b32.done !== 1'b0 || b32.hi !== e_hi32 || b32.lo !== e_lo32) begin
        n_err++;
        $display("FAIL %s run-cycle%0d: busy=%b done=%b hi=%h lo=%h, required busy=1 done=0 hi=%h lo=%h",
                 tag, i + 1, b32.busy, b32.done, b32.hi, b32.lo, e_hi32, e_lo32);
      end
      tick();
    end
    n_cmp++;
    if (b32.busy !== 1'b0 || b32.done !== 1'b1) begin
      n_err++;
      $display("FAIL %s complete: busy=%b done=%b, required busy=0 done=1", tag, b32.busy, b32.done);
    end
    n_cmp++;
    if (b32.hi !== rh || b32.lo !== rl) begin
      n_err++;
      $display("FAIL %s result op=%0d a=%h b=%h: hi=%h lo=%h, required hi=%h lo=%h",
               tag, op, a, b, b32.hi, b32.lo, rh, rl);
    end
    e_hi32 = rh; e_lo32 = rl;
  endtask

  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] rh, rl;
    int lat;
    lat = (op == 3'd2 || op == 3'd3) ? 16 : 1;
    ref_op(16, op, {16'd0, a}, {16'd0, b}, {16'd0, e_hi16}, {16'd0, e_lo16}, rh, rl);
    b16.op = op; b16.a = a; b16.b = b; b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    for (int i = 0; i < lat; i++) begin
      n_cmp++;
      if (b16.busy !== 1'b1 || b16.done !== 1'b0 || b16.hi !== e_hi16 || b16.lo !== e_lo16) begin
        n_err++;
        $display("FAIL sweep16 run-cycle%0d op=%0d: busy=%b done=%b hi=%h lo=%h, required busy=1 done=0 hi=%h lo=%h",
                 i + 1, op, b16.busy, b16.done, b16.hi, b16.lo, e_hi16, e_lo16);
      end
      tick();
    end
    n_cmp++;
    if (b16.busy !== 1'b0 || b16.done !== 1'b1 || b16.hi !== rh[15:0] || b16.lo !== rl[15:0]) begin
      n_err++;
      $display("FAIL sweep16 result op=%0d a=%h b=%h: busy=%b done=%b hi=%h lo=%h, required busy=0 done=1 hi=%h lo=%h",
               op, a, b, b16.busy, b16.done, b16.hi, b16.lo, rh[15:0], rl[15:0]);
    end
    e_hi16 = rh[15:0]; e_lo16 = rl[15:0];
  endtask

  task automatic check_idle32(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    n_cmp++;
    if (b32.busy !== 1'b0 || b32.done !== 1'b0 || b32.hi !== hi || b32.lo !== lo) begin
      n_err++;
      $display("FAIL %s: busy=%b done=%b hi=%h lo=%h, required busy=0 done=0 hi=%h lo=%h",
               tag, b32.busy, b32.done, b32.hi, b32.lo, hi, lo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    e_hi32 = '0; e_lo32 = '0; e_hi16 = '0; e_lo16 = '0;
    check_idle32("reset32", 32'd0, 32'd0);
    n_cmp++;
    if (b16.busy !== 1'b0 || b16.done !== 1'b0 || b16.hi !== 16'd0 || b16.lo !== 16'd0) begin
      n_err++;
      $display("FAIL reset16: busy=%b done=%b hi=%h lo=%h, required all zero",
               b16.busy, b16.done, b16.hi, b16.lo);
    end
  endtask

  task automatic test_mult();
    run32(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg3x7");
    n_cmp++;
    if (b32.hi !== 32'hFFFF_FFFF || b32.lo !== 32'hFFFF_FFEB) begin
      n_err++;
      $display("FAIL mult_const: hi=%h lo=%h, required FFFFFFFF FFFFFFEB", b32.hi, b32.lo);
    end
    tick();
    check_idle32("mult_done_single", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
  endtask

  task automatic test_div();
    run32(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7_2");
    n_cmp++;
    if (b32.lo !== 32'hFFFF_FFFD || b32.hi !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL div_const: hi=%h lo=%h, required FFFFFFFF FFFFFFFD", b32.hi, b32.lo);
    end
    run32(3'd3, 32'd7, 32'd0, 1'b0, "divu_by_zero");
    n_cmp++;
    if (b32.lo !== 32'hFFFF_FFFF || b32.hi !== 32'd7) begin
      n_err++;
      $display("FAIL divzero_const: hi=%h lo=%h, required 00000007 FFFFFFFF", b32.hi, b32.lo);
    end
    run32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    n_cmp++;
    if (b32.lo !== 32'h8000_0000 || b32.hi !== 32'd0) begin
      n_err++;
      $display("FAIL divovf_const: hi=%h lo=%h, required 00000000 80000000", b32.hi, b32.lo);
    end
  endtask

  task automatic test_mthi_madd();
    b32.a = 32'd5; b32.wr_hi = 1'b1;
    tick();
    b32.wr_hi = 1'b0;
    e_hi32 = 32'd5;
    check_idle32("mthi", 32'd5, e_lo32);
    b32.a = 32'd1; b32.wr_lo = 1'b1;
    tick();
    b32.wr_lo = 1'b0;
    e_lo32 = 32'd1;
    check_idle32("mtlo", 32'd5, 32'd1);
    run32(3'd5, 32'hFFFF_FFFF, 32'd2, 1'b0, "maddu");
    n_cmp++;
    if (b32.hi !== 32'd6 || b32.lo !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL maddu_const: hi=%h lo=%h, required 00000006 FFFFFFFF", b32.hi, b32.lo);
    end
    b32.a = 32'h1234_5678; b32.wr_hi = 1'b1; b32.wr_lo = 1'b1;
    tick();
    b32.wr_hi = 1'b0; b32.wr_lo = 1'b0;
    e_hi32 = 32'h1234_5678; e_lo32 = 32'h1234_5678;
    check_idle32("mthi_mtlo_same_cycle", 32'h1234_5678, 32'h1234_5678);
  endtask

  task automatic test_priority();
    run32(3'd0, 32'd3, 32'd4, 1'b1, "start_beats_wr");
    tick();
    b32.clear = 1'b1; b32.start = 1'b1; b32.op = 3'd0; b32.a = 32'd9; b32.b = 32'd9;
    b32.wr_hi = 1'b1; b32.wr_lo = 1'b1;
    tick();
    b32.clear = 1'b0; b32.start = 1'b0; b32.wr_hi = 1'b0; b32.wr_lo = 1'b0;
    check_idle32("clear_idle_suppress", e_hi32, e_lo32);
    tick();
    check_idle32("clear_idle_no_done", e_hi32, e_lo32);
  endtask

  task automatic test_clear();
    b32.op = 3'd0; b32.a = 32'd100; b32.b = 32'd100; b32.start = 1'b1;
    tick();
    b32.start = 1'b0;
    tick();
    tick();
    b32.clear = 1'b1;
    tick();
    b32.clear = 1'b0;
    check_idle32("clear_run", e_hi32, e_lo32);
    tick();
    check_idle32("clear_run_no_done", e_hi32, e_lo32);
    run32(3'd6, 32'd11, 32'd13, 1'b0, "after_clear");
    b32.op = 3'd1; b32.a = 32'hDEAD_BEEF; b32.b = 32'd3; b32.start = 1'b1;
    tick();
    b32.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    b32.clear = 1'b1;
    tick();
    b32.clear = 1'b0;
    check_idle32("clear_at_expiry", e_hi32, e_lo32);
  endtask

  task automatic test_rst_mid();
    b32.op = 3'd2; b32.a = 32'd1000; b32.b = 32'd7; b32.start = 1'b1;
    tick();
    b32.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e_hi32 = '0; e_lo32 = '0; e_hi16 = '0; e_lo16 = '0;
    check_idle32("rst_mid_div", 32'd0, 32'd0);
    b32.op = 3'd0; b32.a = 32'd6; b32.b = 32'd7; b32.start = 1'b1;
    tick();
    b32.op = 3'd2; b32.a = 32'd100; b32.b = 32'd3;
    tick();
    tick();
    b32.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (b32.done !== 1'b1 || b32.busy !== 1'b0 || b32.hi !== 32'd0 || b32.lo !== 32'd42) begin
      n_err++;
      $display("FAIL start_while_busy: busy=%b done=%b hi=%h lo=%h, required busy=0 done=1 hi=0 lo=2a",
               b32.busy, b32.done, b32.hi, b32.lo);
    end
    e_hi32 = 32'd0; e_lo32 = 32'd42;
    tick();
    check_idle32("start_while_busy_ignored", 32'd0, 32'd42);
  endtask

  task automatic test_random32();
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run32(3'($urandom_range(0, 7)), a, b, 1'b0, "random32");
    end
  endtask

  task automatic test_sweep16();
    logic [15:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      case ($urandom_range(0, 9))
        0: b = 16'd0;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: b = 16'($urandom_range(1, 9));
        3: begin
          b16.a = a; b16.wr_hi = 1'b1; b16.wr_lo = ($urandom_range(0, 1) == 1);
          tick();
          e_hi16 = a;
          if (b16.wr_lo) e_lo16 = a;
          b16.wr_hi = 1'b0; b16.wr_lo = 1'b0;
          a = 16'($urandom);
        end
        default: ;
      endcase
      run16(3'($urandom_range(0, 7)), a, b);
    end
  endtask

  initial begin
    rst = 1'b1;
    b32.start = 1'b0; b32.op = 3'd0; b32.a = '0; b32.b = '0;
    b32.wr_hi = 1'b0; b32.wr_lo = 1'b0; b32.clear = 1'b0;
    b16.start = 1'b0; b16.op = 3'd0; b16.a = '0; b16.b = '0;
    b16.wr_hi = 1'b0; b16.wr_lo = 1'b0; b16.clear = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_madd();
    test_priority();
    test_clear();
    test_rst_mid();
    test_random32();
    test_sweep16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
